// File: rtl/reorder_seq.sv
`default_nettype none
// ============================================================================
// Module   : reorder_seq
// Purpose  : Collects one word from each enabled requester lane, then issues
//            the frame transposed as one bit-slice per bit index, with
//            valid/ready flow control, abort and a frame-done pulse.
// Revision : 1.0  initial release
// ============================================================================
module reorder_seq #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 32,
    localparam int IW         = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SW_INST-1:0]         cfg_lane_en,
    input  logic                           abort,
    input  logic [NUM_SW_INST-1:0]         req_valid,
    input  logic [W_WIDTH*NUM_SW_INST-1:0] req_data,
    output logic [NUM_SW_INST-1:0]         req_ready,
    output logic                           slice_valid,
    input  logic                           slice_ready,
    output logic [NUM_SW_INST-1:0]         slice_data,
    output logic [IW-1:0]                  slice_idx,
    output logic                           slice_last,
    output logic [W_WIDTH*NUM_SW_INST-1:0] frame_data,
    output logic                           frame_done
);

    localparam logic [IW-1:0] c_last_idx = IW'(W_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_ISSUE   = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_SW_INST-1:0]   r_captured;
    logic [NUM_SW_INST-1:0]   r_lane_en_q;
    logic [W_WIDTH-1:0]       r_words [NUM_SW_INST];
    logic [IW-1:0]            r_slice_idx;
    logic                     r_frame_done;

    logic [NUM_SW_INST-1:0]   w_ready;
    logic [NUM_SW_INST-1:0]   w_hs;
    logic                     w_frame_full;
    logic                     w_issue;
    logic                     w_slice_acc;
    logic                     w_slice_last;

    // Next-state and handshake decode; abort suppresses every handshake.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = '0;
        w_hs         = '0;
        w_frame_full = 1'b0;
        w_slice_acc  = 1'b0;
        w_issue      = (r_state == ST_ISSUE);
        w_slice_last = w_issue && (r_slice_idx == c_last_idx);
        case (r_state)
            ST_COLLECT: begin
                w_ready      = r_lane_en_q & ~r_captured;
                w_hs         = req_valid & w_ready & {NUM_SW_INST{~abort}};
                // Disabled lanes count as already captured.
                w_frame_full = (&(r_captured | w_hs | ~r_lane_en_q)) && (|r_lane_en_q);
                if (!abort && w_frame_full) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_slice_acc = slice_ready && !abort;
                if (abort || (w_slice_acc && w_slice_last)) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture flags, lane-enable snapshot, slice index and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_captured   <= '0;
            r_lane_en_q  <= '0;
            r_slice_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_slice_acc && w_slice_last;
            // The enable snapshot follows config only while no lane of the
            // current frame has been taken, so a frame never changes shape.
            if ((r_state == ST_COLLECT) && (r_captured == '0) && (w_hs == '0)) begin
                r_lane_en_q <= cfg_lane_en;
            end
            if (abort) begin
                r_captured  <= '0;
                r_slice_idx <= '0;
            end else if (r_state == ST_COLLECT) begin
                r_captured  <= r_captured | w_hs;
                r_slice_idx <= '0;
            end else if (w_slice_acc) begin
                if (w_slice_last) begin
                    r_captured  <= '0;
                    r_slice_idx <= '0;
                end else begin
                    r_slice_idx <= r_slice_idx + IW'(1);
                end
            end
        end
    end

    // Word storage for each lane that completes a handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SW_INST; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW_INST; i++) begin
                if (w_hs[i]) begin
                    r_words[i] <= req_data[i*W_WIDTH +: W_WIDTH];
                end
            end
        end
    end

    // Transposed views; disabled lanes read as zero, everything zero outside ISSUE.
    generate
        for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_lane
            assign slice_data[gi] = w_issue & r_lane_en_q[gi] & r_words[gi][r_slice_idx];
            for (genvar gj = 0; gj < W_WIDTH; gj++) begin : g_bit
                assign frame_data[NUM_SW_INST*gj + gi] = w_issue & r_lane_en_q[gi] & r_words[gi][gj];
            end
        end
    endgenerate

    assign req_ready   = w_ready;
    assign slice_valid = w_issue;
    assign slice_idx   = r_slice_idx;
    assign slice_last  = w_slice_last;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: doc/reorder_seq.md
REORDER_SEQ -- requirements
Module: reorder_seq

Interface
REQ-001 Parameter NUM_SW_INST, default 5, number of switch-instance requester lanes.
REQ-002 Parameter W_WIDTH, default 32, word width per lane; slice index width IW = clog2(W_WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cfg_lane_en  input  NUM_SW_INST  per-lane enable for the next frame.
REQ-006 abort  input  1  discard current frame, return to COLLECT.
REQ-007 req_valid  input  NUM_SW_INST  lane i word offered.
REQ-008 req_data  input  W_WIDTH*NUM_SW_INST  lane i word at bits [i*W_WIDTH +: W_WIDTH].
REQ-009 req_ready  output  NUM_SW_INST  lane i word accepted when req_valid[i] and req_ready[i].
REQ-010 slice_valid  output  1  bit-slice available.
REQ-011 slice_ready  input  1  downstream accepts slice.
REQ-012 slice_data  output  NUM_SW_INST  slice_data[i] = captured word of lane i, bit slice_idx.
REQ-013 slice_idx  output  IW  current bit index j.
REQ-014 slice_last  output  1  high with slice_valid when slice_idx = W_WIDTH-1.
REQ-015 frame_data  output  W_WIDTH*NUM_SW_INST  full transposed frame: bit NUM_SW_INST*j+i = lane i bit j; valid while slice_valid.
REQ-016 frame_done  output  1  one-cycle pulse after last slice accepted.

Function
REQ-017 Two states: COLLECT and ISSUE; a captured[NUM_SW_INST] flag vector and lane_en_q register.
REQ-018 In COLLECT with captured all zero, lane_en_q SHALL load cfg_lane_en every cycle; once any lane is captured lane_en_q is frozen until the frame ends.
REQ-019 In COLLECT, req_ready[i] = lane_en_q[i] and not captured[i]; req_ready is 0 in ISSUE.
REQ-020 Any subset of lanes may handshake in the same cycle; each handshaking lane's word is stored and captured[i] set on that edge.
REQ-021 Disabled lanes SHALL contribute all-zero words and count as captured.
REQ-022 When all lanes are captured (including lanes completing this cycle) and lane_en_q is nonzero, the state SHALL become ISSUE on the next edge with slice_idx = 0.
REQ-023 lane_en_q all zero: remain in COLLECT, no frame issued.
REQ-024 In ISSUE slice_valid = 1; slice_data and slice_idx SHALL hold stable while slice_ready = 0.
REQ-025 On slice_valid and slice_ready with slice_idx < W_WIDTH-1, slice_idx increments by 1.
REQ-026 On acceptance with slice_last: return to COLLECT, clear captured, slice_idx = 0, frame_done = 1 for the next cycle only.
REQ-027 Latency: first slice valid exactly one cycle after the final lane handshake; W_WIDTH slices with slice_ready held high take W_WIDTH cycles.
REQ-028 abort in any state SHALL on the next edge force COLLECT, clear captured, slice_idx = 0, no frame_done; abort wins over a simultaneous lane or slice handshake (the handshake is dropped; req_ready is still observed high that cycle, and upstream must re-offer).
REQ-029 frame_data is a pure rearrangement of stored words; no arithmetic; outputs zero when slice_valid = 0.

Reset
REQ-030 While rst_n = 0 at a clock edge: state = COLLECT, captured = 0, lane_en_q = 0, slice_idx = 0, frame_done = 0, stored words = 0.
REQ-031 Reset values of outputs: req_ready = 0 (the first cycle after reset), slice_valid = 0, slice_data = 0, slice_last = 0, frame_data = 0, frame_done = 0.
REQ-032 Reset asserted mid-ISSUE SHALL discard the frame identically to abort, with no frame_done.

Verification
REQ-033 All 5 lanes enabled, words 0xFFFFFFFF,0,0,0,0 offered same cycle, slice_ready=1 -> ISSUE next cycle, 32 slices each slice_data=5'b00001, slice_last on idx 31, frame_done one cycle later.
REQ-034 Lanes offered on different cycles (lane 3 last, word 0x80000000, others 0) -> first slice one cycle after lane 3 handshake; only slice 31 has slice_data=5'b01000.
REQ-035 cfg_lane_en=5'b00101, lanes 0/2 send 0x00000001 -> req_ready[1,3,4]=0; slice 0 = 5'b00101, slices 1..31 = 0.
REQ-036 slice_ready toggled 1,0,0,1 during ISSUE -> slice_idx/slice_data stable through stalls; total 32 accepted slices, no skips.
REQ-037 abort asserted at slice_idx=10 coincident with slice_ready -> next cycle COLLECT, slice_valid=0, no frame_done; new frame then issues from idx 0.
REQ-038 rst_n low for one cycle mid-COLLECT with 3 lanes captured -> all captured cleared; those lanes show req_ready high again after reset.
